// File: rtl/rot_regfile_reader.sv
// Reads one 32-bit register from a nibble-serial register file. Eight nibbles
// are collected over one full pass of the shared phase counter, then presented as a single word.
module rot_regfile_reader #(
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           counter,
  output logic [ADDR_BITS-1:0] rf_addr,
  input  logic [3:0]           rf_data,
  input  logic                 req_valid,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_data,
  input  logic                 rsp_ready
);

  typedef enum logic [1:0] {IDLE, ALIGN, CAPTURE, RESP} state_t;

  state_t               r_state;
  logic [ADDR_BITS-1:0] r_addr;
  logic [27:0]          r_buf;
  logic [31:0]          r_rspData;
  logic                 r_reqReady;
  logic                 r_rspValid;
  logic [4:0]           w_slot;

  assign w_slot    = {counter, 2'b00};
  assign rf_addr   = r_addr;
  assign req_ready = r_reqReady;
  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;

  // Nibbles 0..6 go into a staging buffer so that rsp_data keeps the previous
  // word until the new one is complete; nibble 7 commits the whole word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_buf      <= '0;
      r_rspData  <= '0;
      r_reqReady <= 1'b1;
      r_rspValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr     <= req_addr;
            r_reqReady <= 1'b0;
            r_state    <= ALIGN;
          end
        end
        ALIGN: begin
          if (counter == 3'd0) begin
            r_buf[3:0] <= rf_data;
            r_state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (counter == 3'd7) begin
            r_rspData  <= {rf_data, r_buf};
            r_rspValid <= 1'b1;
            r_state    <= RESP;
          end else begin
            r_buf[w_slot +: 4] <= rf_data;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rspValid <= 1'b0;
            r_reqReady <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rot_regfile_reader.sv
// Directed bench for rot_regfile_reader: a behavioural nibble-serial register file
// answers rf_addr, and each read is checked for latency, data and handshake behaviour.
module tb_rot_regfile_reader;

  logic        clk;
  logic        rst;
  logic [2:0]  counter;
  logic [3:0]  rfAddr;
  logic [3:0]  rfData;
  logic        reqValid;
  logic [3:0]  reqAddr;
  logic        reqReady;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspReady;

  logic [31:0] regs [16];
  int          compareCount;
  int          mismatchCount;
  int          hsCount;

  rot_regfile_reader #(.ADDR_BITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .counter   (counter),
    .rf_addr   (rfAddr),
    .rf_data   (rfData),
    .req_valid (reqValid),
    .req_addr  (reqAddr),
    .req_ready (reqReady),
    .rsp_valid (rspValid),
    .rsp_data  (rspData),
    .rsp_ready (rspReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running phase counter, updated just after each rising edge.
  initial counter = 3'd0;
  always @(posedge clk) begin
    #1;
    counter = counter + 3'd1;
  end

  always_comb rfData = regs[rfAddr][{counter, 2'b00} +: 4];

  always @(negedge clk) begin
    if (rspValid && rspReady) hsCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic waitCounter(input logic [2:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (counter != c && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (counter != c) checkOutput("waitCounter", {29'd0, counter}, {29'd0, c});
  endtask

  // One read: request at phase cnt, measure latency, hold rsp_ready low for
  // hold cycles, then complete the handshake and confirm the return to IDLE.
  task automatic applyStimulus(input string tag, input logic [3:0] addr, input logic [2:0] cnt,
                               input int hold, input int expLat, input logic [31:0] expData);
    int lat;
    int addrBad;
    int readyBad;
    int holdBad;
    addrBad  = 0;
    readyBad = 0;
    holdBad  = 0;
    rspReady = 1'b0;
    waitCounter(cnt);
    checkOutput({tag, "_reqReadyIdle"}, {31'd0, reqReady}, 32'd1);
    reqValid = 1'b1;
    reqAddr  = addr;
    lat = 0;
    @(negedge clk);
    reqValid = 1'b0;
    lat = 1;
    while (!rspValid && lat < 40) begin
      if (rfAddr !== addr) addrBad++;
      if (reqReady !== 1'b0) readyBad++;
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_rfAddr"}, addrBad, 0);
    checkOutput({tag, "_reqReadyBusy"}, readyBad, 0);
    checkOutput({tag, "_data"}, rspData, expData);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rspValid !== 1'b1 || rspData !== expData || reqReady !== 1'b0) holdBad++;
    end
    if (hold > 0) checkOutput({tag, "_holdStable"}, holdBad, 0);
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput({tag, "_reqReadyAfter"}, {31'd0, reqReady}, 32'd1);
    checkOutput({tag, "_rspValidAfter"}, {31'd0, rspValid}, 32'd0);
    checkOutput({tag, "_dataRetained"}, rspData, expData);
  endtask

  initial begin
    int n;
    int addrBad;
    int pulses;
    compareCount  = 0;
    mismatchCount = 0;
    hsCount       = 0;
    for (int i = 0; i < 16; i++) regs[i] = 32'h1111_1111 * i;
    rst      = 1'b1;
    reqValid = 1'b0;
    reqAddr  = 4'd9;
    rspReady = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_reqReady", {31'd0, reqReady}, 32'd1);
    checkOutput("rst_rspValid", {31'd0, rspValid}, 32'd0);
    checkOutput("rst_rfAddr", {28'd0, rfAddr}, 32'd0);
    checkOutput("rst_rspData", rspData, 32'd0);
    rst = 1'b0;

    // Back-to-back reads of every register with rsp_ready held high.
    $display("[TB] back-to-back sweep");
    rspReady = 1'b1;
    @(negedge clk);
    hsCount = 0;
    for (int i = 0; i < 16; i++) begin
      reqValid = 1'b1;
      reqAddr  = 4'(i);
      @(negedge clk);
      reqValid = 1'b0;
      n = 0;
      while (!rspValid && n < 40) begin
        @(negedge clk);
        n++;
      end
      checkOutput($sformatf("b2b_data%0d", i), rspData, 32'h1111_1111 * i);
      @(negedge clk);
    end
    rspReady = 1'b0;
    @(negedge clk);
    checkOutput("b2b_handshakes", hsCount, 16);

    regs[5]  = 32'h89AB_CDEF;
    regs[15] = 32'h1234_5678;
    regs[2]  = 32'h0000_000F;
    regs[3]  = 32'hA5A5_3C3C;
    regs[4]  = 32'h0F1E_2D3C;

    $display("[TB] directed reads");
    applyStimulus("r5c7", 4'd5, 3'd7, 0, 9, 32'h89AB_CDEF);
    applyStimulus("r5c0", 4'd5, 3'd0, 0, 16, 32'h89AB_CDEF);
    applyStimulus("r15hold", 4'd15, 3'd2, 5, 14, 32'h1234_5678);

    // Request held while busy with the address changing mid-capture.
    $display("[TB] ignored request while busy");
    waitCounter(3'd7);
    reqValid = 1'b1;
    reqAddr  = 4'd3;
    addrBad  = 0;
    n = 0;
    @(negedge clk);
    while (!rspValid && n < 40) begin
      if (counter == 3'd3) reqAddr = 4'd4;
      if (rfAddr !== 4'd3) addrBad++;
      @(negedge clk);
      n++;
    end
    checkOutput("busy_rfAddr", addrBad, 0);
    checkOutput("busy_data", rspData, 32'hA5A5_3C3C);
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput("busy_idleReady", {31'd0, reqReady}, 32'd1);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("busy_secondAccepted", {31'd0, reqReady}, 32'd0);
    checkOutput("busy_secondAddr", {28'd0, rfAddr}, 32'd4);
    n = 0;
    while (!rspValid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_secondData", rspData, 32'h0F1E_2D3C);
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;

    // Reset in the middle of a capture pass.
    $display("[TB] reset mid-capture");
    waitCounter(3'd7);
    reqValid = 1'b1;
    reqAddr  = 4'd15;
    @(negedge clk);
    reqValid = 1'b0;
    waitCounter(3'd4);
    rst = 1'b1;
    #1;
    checkOutput("midRst_rspValid", {31'd0, rspValid}, 32'd0);
    checkOutput("midRst_rfAddr", {28'd0, rfAddr}, 32'd0);
    checkOutput("midRst_reqReady", {31'd0, reqReady}, 32'd1);
    checkOutput("midRst_rspData", rspData, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rspValid) pulses++;
    end
    checkOutput("midRst_noPulse", pulses, 0);
    applyStimulus("r2afterRst", 4'd2, 3'd3, 0, 13, 32'h0000_000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
